// File: rtl/trace_pkg.sv
// Shared types for the trace request queue: op encoding, queued entry layout,
// DRAM address field positions and a saturating time increment.
package trace_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_IFETCH  = 2'd2,
    OP_ILLEGAL = 2'd3
  } trace_op_e;

  // "time" is a reserved word, so the request time field is req_time.
  typedef struct packed {
    logic [31:0] req_time;
    trace_op_e   op;
    logic [31:0] addr;
  } trace_entry_t;

  localparam int COL_LSB  = 3;
  localparam int COL_MSB  = 12;
  localparam int BG_LSB   = 13;
  localparam int BG_MSB   = 14;
  localparam int BANK_LSB = 15;
  localparam int BANK_MSB = 16;
  localparam int ROW_LSB  = 17;
  localparam int ROW_MSB  = 31;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/trace_addr_decode.sv
// Combinational split of a byte address into DRAM row / bank group / bank / column.
// The byte offset within the 8-byte burst word is discarded.
module trace_addr_decode
  import trace_pkg::*;
(
  input  logic [31:0] addr,
  output logic [14:0] row,
  output logic [1:0]  bg,
  output logic [1:0]  bank,
  output logic [9:0]  col
);

  logic unused_byte_offset;

  assign col  = addr[COL_MSB:COL_LSB];
  assign bg   = addr[BG_MSB:BG_LSB];
  assign bank = addr[BANK_MSB:BANK_LSB];
  assign row  = addr[ROW_MSB:ROW_LSB];

  assign unused_byte_offset = ^addr[COL_LSB-1:0];

endmodule

// File: rtl/trace_request_queue.sv
// Time-released FIFO of parsed trace requests feeding a memory controller.
// Define TRACE_QUEUE_DEBUG_EN to print every push, drop and pop.
module trace_request_queue
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_time,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_addr,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [1:0]       req_op,
  output logic [31:0]      req_addr,
  output logic [14:0]      req_row,
  output logic [1:0]       req_bg,
  output logic [1:0]       req_bank,
  output logic [9:0]       req_col,
  output logic [31:0]      sim_time,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic [15:0]      drop_cnt,
  output logic             order_err
);

  localparam int PTR_W = $clog2(DEPTH);

  trace_entry_t     mem [DEPTH];
  trace_entry_t     head;
  trace_entry_t     in_entry;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      last_time;

  logic accept;
  logic is_illegal;
  logic push;
  logic drop;
  logic pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign in_ready   = !full;
  assign accept     = in_valid && in_ready;
  assign is_illegal = (trace_op_e'(in_op) == OP_ILLEGAL);
  assign push       = accept && !is_illegal;
  assign drop       = accept && is_illegal;

  assign in_entry.req_time = in_time;
  assign in_entry.op       = trace_op_e'(in_op);
  assign in_entry.addr     = in_addr;

  // Head is read straight from the storage array, so release depends only on flops.
  assign head      = mem[rd_ptr];
  assign req_valid = !empty && (head.req_time <= sim_time);
  assign pop       = req_valid && req_ready;
  assign req_op    = head.op;
  assign req_addr  = head.addr;

  trace_addr_decode u_head_decode (
    .addr (head.addr),
    .row  (req_row),
    .bg   (req_bg),
    .bank (req_bank),
    .col  (req_col)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sim_time  <= '0;
      drop_cnt  <= '0;
      order_err <= 1'b0;
      last_time <= '0;
    end else begin
      sim_time <= sat_inc32(sim_time);
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      // Out-of-order entries are still queued; the flag just records that it happened.
      if (push) begin
        last_time <= in_time;
        if (in_time < last_time) begin
          order_err <= 1'b1;
        end
      end
    end
  end

`ifdef TRACE_QUEUE_DEBUG_EN
  logic [14:0] dbg_in_row;
  logic [1:0]  dbg_in_bg;
  logic [1:0]  dbg_in_bank;
  logic [9:0]  dbg_in_col;

  trace_addr_decode u_in_decode (
    .addr (in_addr),
    .row  (dbg_in_row),
    .bg   (dbg_in_bg),
    .bank (dbg_in_bank),
    .col  (dbg_in_col)
  );

  always @(posedge clk) begin
    if (!rst) begin
      if (push)
        $display("[trq] t=%0d push op=%0d addr=%08h row=%0h bg=%0d bank=%0d col=%0h",
                 sim_time, in_op, in_addr, dbg_in_row, dbg_in_bg, dbg_in_bank, dbg_in_col);
      if (drop)
        $display("[trq] t=%0d drop op=%0d addr=%08h row=%0h bg=%0d bank=%0d col=%0h",
                 sim_time, in_op, in_addr, dbg_in_row, dbg_in_bg, dbg_in_bank, dbg_in_col);
      if (pop)
        $display("[trq] t=%0d pop  op=%0d addr=%08h row=%0h bg=%0d bank=%0d col=%0h",
                 sim_time, req_op, req_addr, req_row, req_bg, req_bank, req_col);
    end
  end
`endif

endmodule

// File: tb/tb_trace_request_queue.sv
// Self-checking bench for trace_request_queue: directed scenarios plus randomized
// traffic compared every cycle against a queue-based reference model.
module tb_trace_request_queue;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_time;
  logic [1:0]       in_op;
  logic [31:0]      in_addr;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_addr;
  logic [14:0]      req_row;
  logic [1:0]       req_bg;
  logic [1:0]       req_bank;
  logic [9:0]       req_col;
  logic [31:0]      sim_time;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic [15:0]      drop_cnt;
  logic             order_err;

  trace_request_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_time   (in_time),
    .in_op     (in_op),
    .in_addr   (in_addr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_row   (req_row),
    .req_bg    (req_bg),
    .req_bank  (req_bank),
    .req_col   (req_col),
    .sim_time  (sim_time),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .drop_cnt  (drop_cnt),
    .order_err (order_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] t;
    logic [1:0]  op;
    logic [31:0] addr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_time;
  logic [15:0] m_drop;
  logic        m_oerr;
  logic [31:0] m_last;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_valid();
    return (q.size() > 0) && (q[0].t <= m_time);
  endfunction

  task automatic compare();
    chk("count",     count,     q.size());
    chk("full",      full,      q.size() == DEPTH);
    chk("empty",     empty,     q.size() == 0);
    chk("in_ready",  in_ready,  q.size() < DEPTH);
    chk("sim_time",  sim_time,  m_time);
    chk("drop_cnt",  drop_cnt,  m_drop);
    chk("order_err", order_err, m_oerr);
    chk("req_valid", req_valid, m_valid());
    if (m_valid()) begin
      chk("req_op",   req_op,   q[0].op);
      chk("req_addr", req_addr, q[0].addr);
      chk("req_col",  req_col,  (q[0].addr / 8) % 1024);
      chk("req_bg",   req_bg,   (q[0].addr / 8192) % 4);
      chk("req_bank", req_bank, (q[0].addr / 32768) % 4);
      chk("req_row",  req_row,  q[0].addr / 131072);
    end
  endtask

  // Inputs are already driven (at a negedge); advance one clock, update model, compare.
  task automatic cycle();
    bit acc;
    bit pop;
    acc = in_valid && (q.size() < DEPTH);
    pop = m_valid() && req_ready;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_time = '0;
      m_drop = '0;
      m_oerr = 1'b0;
      m_last = '0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        if (in_op == 2'd3) begin
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end else begin
          if (in_time < m_last) m_oerr = 1'b1;
          m_last = in_time;
          q.push_back('{t: in_time, op: in_op, addr: in_addr});
        end
      end
      if (m_time != 32'hFFFF_FFFF) m_time = m_time + 32'd1;
    end
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] t, input logic [1:0] op, input logic [31:0] addr);
    in_valid = 1'b1;
    in_time  = t;
    in_op    = op;
    in_addr  = addr;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a0;
    logic [1:0]  op0;
    logic [9:0]  col0;
    int          seen;
    int          pop_cyc[2];
    logic [31:0] pop_addr[2];
    int          npop;

    rst = 1'b1; in_valid = 1'b0; in_time = '0; in_op = '0; in_addr = '0; req_ready = 1'b0;
    q.delete(); m_time = '0; m_drop = '0; m_oerr = 1'b0; m_last = '0;
    @(negedge clk);

    // Reset state and first-release timing with address decode
    do_reset();
    chk("rst_empty",    empty,     1);
    chk("rst_in_ready", in_ready,  1);
    chk("rst_valid",    req_valid, 0);
    chk("rst_time",     sim_time,  0);
    push(32'd5, 2'd0, 32'h0001_2348);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (req_valid) begin
        seen = 1;
        chk("rel_time",  sim_time, 5);
        chk("rel_col",   req_col,  10'h069);
        chk("rel_bg",    req_bg,   1);
        chk("rel_bank",  req_bank, 2);
        chk("rel_row",   req_row,  0);
      end else begin
        cycle();
      end
    end
    if (!seen) chk("rel_timeout", 0, 1);

    // Fill to full, refuse the 17th, then one-cycle pop while full
    do_reset();
    req_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(32'd0, 2'(i % 3), $urandom);
    chk("full_flag",  full,     1);
    chk("full_ready", in_ready, 0);
    chk("full_count", count,    16);
    push(32'd0, 2'd1, 32'hDEAD_BEE8);
    chk("full_17th", count, 16);
    in_valid = 1'b1; in_op = 2'd0; in_time = 32'd0; in_addr = 32'h1234_5678;
    req_ready = 1'b1;
    cycle();
    in_valid = 1'b0; req_ready = 1'b0;
    chk("full_pop", count, 15);

    // Illegal ops are dropped, not stored
    do_reset();
    repeat (3) push(32'd0, 2'd3, $urandom);
    push(32'd0, 2'd1, 32'h0ABC_DEF0);
    chk("drop_cnt3",  drop_cnt, 3);
    chk("drop_count", count,    1);
    chk("drop_headop",   req_op,   1);
    chk("drop_headaddr", req_addr, 32'h0ABC_DEF0);

    // Out-of-order times: flag set, entries issue back to back in push order
    do_reset();
    push(32'd100, 2'd0, 32'h0000_1000);
    push(32'd50,  2'd1, 32'h0000_2000);
    chk("oerr", order_err, 1);
    req_ready = 1'b1;
    npop = 0;
    for (int i = 0; i < 200 && npop < 2; i++) begin
      if (req_valid) begin
        pop_cyc[npop]  = i;
        pop_addr[npop] = req_addr;
        npop++;
      end
      cycle();
    end
    req_ready = 1'b0;
    chk("oerr_npop", npop, 2);
    if (npop == 2) begin
      chk("oerr_first",  pop_addr[0], 32'h0000_1000);
      chk("oerr_second", pop_addr[1], 32'h0000_2000);
      chk("oerr_b2b",    pop_cyc[1],  pop_cyc[0] + 1);
    end

    // Stall holds outputs; reset mid-operation discards everything
    do_reset();
    push(32'd0, 2'd2, 32'h8765_4328);
    push(32'd1, 2'd0, 32'h1111_1118);
    a0 = req_addr; op0 = req_op; col0 = req_col;
    chk("stall_valid", req_valid, 1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("stall_addr", req_addr, a0);
      chk("stall_op",   req_op,   op0);
      chk("stall_col",  req_col,  col0);
    end
    rst = 1'b1;
    cycle();
    chk("mid_rst_count", count,     0);
    chk("mid_rst_valid", req_valid, 0);
    chk("mid_rst_time",  sim_time,  0);
    rst = 1'b0;

    // Randomized traffic with varying offer/accept pressure
    for (int ph = 0; ph < 6; ph++) begin
      int pv;
      int pr;
      do_reset();
      pv = $urandom_range(20, 95);
      pr = $urandom_range(5, 90);
      for (int c = 0; c < 400; c++) begin
        in_valid = ($urandom_range(0, 99) < pv);
        in_op    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        in_addr  = $urandom;
        if ($urandom_range(0, 19) == 0)
          in_time = (m_time > 32'd10) ? m_time - 32'd10 : 32'd0;
        else
          in_time = m_time + 32'($urandom_range(0, 30));
        req_ready = ($urandom_range(0, 99) < pr);
        rst = ($urandom_range(0, 499) == 0);
        cycle();
      end
      rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_request_queue.md
TRACE_REQUEST_QUEUE -- requirements
Module: trace_request_queue

Interface
REQ-001 Parameter: DEPTH, 16, queue entries (power of two, 2..64).
REQ-002 Parameter: CNT_W, $clog2(DEPTH)+1, occupancy counter width.
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: in_valid  in  1  parsed trace line offered.
REQ-006 Port: in_ready  out  1  queue accepts the offered line this cycle.
REQ-007 Port: in_time  in  32  trace request time, CPU clocks.
REQ-008 Port: in_op  in  2  0 read, 1 write, 2 instruction fetch, 3 illegal.
REQ-009 Port: in_addr  in  32  byte address.
REQ-010 Port: req_valid  out  1  head request is due and presented.
REQ-011 Port: req_ready  in  1  downstream controller takes the request.
REQ-012 Port: req_op  out  2, req_addr  out  32  head op and address.
REQ-013 Port: req_row  out  15, req_bg  out  2, req_bank  out  2, req_col  out  10  decoded head address.
REQ-014 Port: sim_time  out  32  current simulation time, CPU clocks.
REQ-015 Port: count  out  CNT_W, full  out  1, empty  out  1  occupancy status.
REQ-016 Port: drop_cnt  out  16, order_err  out  1  illegal-op drop counter; sticky time-order error.

Function
REQ-017 Transfer in: occurs when in_valid and in_ready both high; in_ready SHALL equal !full.
REQ-018 Illegal op (3): accepted, not stored; drop_cnt increments, saturating at 16'hFFFF.
REQ-019 Ordering: FIFO, in order; stored entries are never reordered or skipped.
REQ-020 sim_time: increments by 1 every cycle; saturates at 32'hFFFF_FFFF.
REQ-021 Release: req_valid = !empty and head time <= sim_time (unsigned compare); derived from registered state only, with no combinational path from in_* or req_ready.
REQ-022 Latency: an entry pushed into an empty queue in cycle N is visible at the head in cycle N+1, never in cycle N.
REQ-023 Handshake: while req_valid and !req_ready, the head entry and all req_* outputs hold stable; the pop occurs on the cycle req_valid and req_ready are both high.
REQ-024 Decode: byte offset addr[2:0] is discarded; req_col=addr[12:3], req_bg=addr[14:13], req_bank=addr[16:15], req_row=addr[31:17].
REQ-025 Simultaneous: a push and a pop in the same cycle SHALL leave count unchanged; when full, in_ready is low, so a same-cycle pop does not admit a push.
REQ-026 Boundaries: pointers wrap modulo DEPTH; count ranges 0..DEPTH; full=(count==DEPTH); empty=(count==0).
REQ-027 Order check: accepting a legal entry with in_time less than the previously accepted legal time SHALL set order_err (sticky); the entry is still queued.

Reset
REQ-028 On rst: count=0, pointers=0, empty=1, full=0, in_ready=1, req_valid=0, sim_time=0, drop_cnt=0, order_err=0, last-time register=0.
REQ-029 Reset mid-operation discards all queued entries; the next rising edge with rst low restarts sim_time from 0.
REQ-030 Memory array contents are not reset; req_op, req_addr and decode outputs are don't-care while req_valid=0.

Configuration
REQ-031 Macro TRACE_QUEUE_DEBUG_EN defined: $display on every push, drop and pop, showing sim_time, op, addr, row, bg, bank and col.
REQ-032 Macro TRACE_QUEUE_DEBUG_EN undefined: no display code is compiled, and cycle behaviour is identical.

Structure
REQ-033 Shared package trace_pkg holds the op enum (OP_READ, OP_WRITE, OP_IFETCH, OP_ILLEGAL), the trace_entry_t struct (time, op, addr) and the address-field bit positions.
REQ-034 Sub-module trace_addr_decode (combinational) performs REQ-024; the FIFO storage stays in this module.

Verification
REQ-035 Reset, then push {time=5, op=0, addr=32'h0001_2348} at cycle 0: req_valid first high when sim_time=5, with req_col=10'h069, req_bg=2, req_bank=2, req_row=0.
REQ-036 Push 16 entries, all time=0, with req_ready=0: full=1, in_ready=0, count=16; the 17th offer is not accepted.
REQ-037 Full queue, req_ready=1 and in_valid=1 for one cycle: one pop, no push, count=15.
REQ-038 Push op=3 three times, then op=1: drop_cnt=3, count=1, and the head holds the op=1 entry.
REQ-039 Push time=100, then time=50: order_err=1; both entries issue in push order, the second immediately after the first.
REQ-040 Hold req_ready=0 for 4 cycles with req_valid=1, then assert rst: req_* outputs stable during the stall; after reset count=0, req_valid=0, sim_time=0.
